dac_cfg_scheduler: RTL and testbench

Frame-synchronous configuration controller for the two-channel DAC/threshold datapath: thresholds, detection windows, edge type, HPF coefficient and enables. The host writes a shadow register bank; on commit, the block validates the bank and copies it to the active outputs atomically at the next sample-frame boundary. No DAC frame ever sees a half-updated configuration. When the HPF coefficient changes or the HPF is enabled, the block gates the HPF off for a settle period. It sits between the host register interface and the DAC datapath inputs.

---
 rtl/dac_cfg_pkg.sv | 77 +++++++
 rtl/dac_cfg_shadow_bank.sv | 52 +++++
 rtl/dac_cfg_scheduler.sv | 178 +++++++++++++++++
 tb/tb_dac_cfg_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dac_cfg_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : dac_cfg_pkg                                                  |
// | Purpose : Shared definitions for the DAC configuration scheduler:      |
// |           shadow address map, state encoding, reset values, control    |
// |           word bit positions, the register-bank record and the bank    |
// |           validation helper.                                           |
// | Ports   : none (package)                                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package dac_cfg_pkg;

  // Shadow register address map
  localparam logic [3:0] ADDR_THRSH_1     = 4'd0;
  localparam logic [3:0] ADDR_THRSH_2     = 4'd1;
  localparam logic [3:0] ADDR_START_WIN_1 = 4'd2;
  localparam logic [3:0] ADDR_STOP_WIN_1  = 4'd3;
  localparam logic [3:0] ADDR_START_WIN_2 = 4'd4;
  localparam logic [3:0] ADDR_STOP_WIN_2  = 4'd5;
  localparam logic [3:0] ADDR_STOP_MAX    = 4'd6;
  localparam logic [3:0] ADDR_HPF_COEF    = 4'd7;
  localparam logic [3:0] ADDR_CTRL        = 4'd8;

  // Scheduler state encoding
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
  localparam logic [1:0] ST_SETTLE     = 2'd2;

  // Reset values (thresholds sit at mid-scale in offset binary)
  localparam logic [15:0] RST_THRSH    = 16'd32768;
  localparam logic [15:0] RST_WIN      = 16'd0;
  localparam logic [15:0] RST_HPF_COEF = 16'd0;
  localparam logic [7:0]  RST_CTRL     = 8'd0;

  // Control word bit positions
  localparam int CTRL_EDGE_LSB   = 0;
  localparam int CTRL_HPF_EN     = 2;
  localparam int CTRL_FSM_MODE   = 3;
  localparam int CTRL_POL_1      = 4;
  localparam int CTRL_POL_2      = 5;
  localparam int CTRL_DAC_EN_LSB = 6;

  // One complete configuration bank; only the meaningful low byte of the
  // control word is kept.
  typedef struct packed {
    logic [15:0] thrsh_1;
    logic [15:0] thrsh_2;
    logic [15:0] start_win_1;
    logic [15:0] stop_win_1;
    logic [15:0] start_win_2;
    logic [15:0] stop_win_2;
    logic [15:0] stop_max;
    logic [15:0] hpf_coef;
    logic [7:0]  ctrl;
  } cfg_bank_t;

  localparam cfg_bank_t CFG_RESET = '{
    thrsh_1     : RST_THRSH,
    thrsh_2     : RST_THRSH,
    start_win_1 : RST_WIN,
    stop_win_1  : RST_WIN,
    start_win_2 : RST_WIN,
    stop_win_2  : RST_WIN,
    stop_max    : RST_WIN,
    hpf_coef    : RST_HPF_COEF,
    ctrl        : RST_CTRL
  };

  // A bank is applicable only if both detection windows are ordered and
  // fit under stop_max (unsigned compares).
  function automatic logic bank_is_valid(input cfg_bank_t b);
    return (b.start_win_1 <= b.stop_win_1) && (b.stop_win_1 <= b.stop_max) &&
           (b.start_win_2 <= b.stop_win_2) && (b.stop_win_2 <= b.stop_max);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dac_cfg_shadow_bank.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : dac_cfg_shadow_bank                                          |
// | Purpose : Host-writable 9x16 shadow register file with write decode    |
// |           and a sticky reserved-address error flag.                    |
// | Ports   : dataclk, reset (async, active-low)                           |
// |           wr_en/wr_addr/wr_data - qualified host write                 |
// |           shadow                - current shadow bank contents         |
// |           addr_err              - sticky, write hit a reserved address |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module dac_cfg_shadow_bank
  import dac_cfg_pkg::*;
(
  input  logic        dataclk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  output cfg_bank_t   shadow,
  output logic        addr_err
);

  cfg_bank_t r_bank;
  logic      r_addr_err;

  always_ff @(posedge dataclk or negedge reset) begin
    if (!reset) begin
      r_bank     <= CFG_RESET;
      r_addr_err <= 1'b0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_THRSH_1:     r_bank.thrsh_1     <= wr_data;
        ADDR_THRSH_2:     r_bank.thrsh_2     <= wr_data;
        ADDR_START_WIN_1: r_bank.start_win_1 <= wr_data;
        ADDR_STOP_WIN_1:  r_bank.stop_win_1  <= wr_data;
        ADDR_START_WIN_2: r_bank.start_win_2 <= wr_data;
        ADDR_STOP_WIN_2:  r_bank.stop_win_2  <= wr_data;
        ADDR_STOP_MAX:    r_bank.stop_max    <= wr_data;
        ADDR_HPF_COEF:    r_bank.hpf_coef    <= wr_data;
        ADDR_CTRL:        r_bank.ctrl        <= wr_data[7:0];
        // Reserved addresses: the write is consumed but only flags an error
        default:          r_addr_err         <= 1'b1;
      endcase
    end
  end

  assign shadow   = r_bank;
  assign addr_err = r_addr_err;

endmodule
`default_nettype wire

// File: rtl/dac_cfg_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : dac_cfg_scheduler                                            |
// | Purpose : Frame-synchronous configuration controller. Validates the    |
// |           shadow bank on commit, copies it atomically to the active    |
// |           outputs at a frame boundary and holds the HPF off for a      |
// |           settle period after a filter change.                         |
// | Ports   : dataclk, reset (async, active-low), frame_start, spi_running |
// |           cfg_valid/cfg_ready/cfg_addr/cfg_data - host write port      |
// |           commit_req, commit_busy/done/err, addr_err - commit status   |
// |           DAC_* / HPF_* - active configuration outputs                 |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module dac_cfg_scheduler
  import dac_cfg_pkg::*;
#(
  parameter int SETTLE_FRAMES = 4
) (
  input  logic        dataclk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        spi_running,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [3:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic        commit_req,
  output logic        commit_busy,
  output logic        commit_done,
  output logic        commit_err,
  output logic        addr_err,
  output logic [15:0] DAC_thrsh_1,
  output logic [15:0] DAC_thrsh_2,
  output logic [15:0] DAC_start_win_1,
  output logic [15:0] DAC_stop_win_1,
  output logic [15:0] DAC_start_win_2,
  output logic [15:0] DAC_stop_win_2,
  output logic [15:0] DAC_stop_max,
  output logic [15:0] HPF_coefficient,
  output logic        HPF_en,
  output logic        DAC_fsm_mode,
  output logic        DAC_thrsh_pol_1,
  output logic        DAC_thrsh_pol_2,
  output logic [1:0]  DAC_edge_type,
  output logic [1:0]  DAC_en
);

  localparam logic [7:0] SETTLE_CNT_INIT = 8'(SETTLE_FRAMES);

  logic [1:0] r_state;
  cfg_bank_t  r_act;
  logic       r_hpf_en_out;
  logic       r_busy;
  logic       r_done;
  logic       r_err;
  logic       r_imm;
  logic [7:0] r_settle_cnt;

  cfg_bank_t  w_shadow;
  logic       w_wr_en;
  logic       w_valid;
  logic       w_apply;
  logic       w_filter_change;
  logic       w_need_settle;
  logic       w_settle_end;

  // Writes are only taken while idle and no commit is being requested, so
  // the shadow bank is frozen from commit until the apply edge.
  assign cfg_ready = (r_state == ST_IDLE) && !commit_req;
  assign w_wr_en   = cfg_valid && cfg_ready;

  dac_cfg_shadow_bank u_shadow_bank (
    .dataclk  (dataclk),
    .reset    (reset),
    .wr_en    (w_wr_en),
    .wr_addr  (cfg_addr),
    .wr_data  (cfg_data),
    .shadow   (w_shadow),
    .addr_err (addr_err)
  );

  assign w_valid = bank_is_valid(w_shadow);

  // r_imm marks a commit taken with SPI stopped: apply on the very next
  // edge even if spi_running comes back meanwhile.
  assign w_apply = (r_state == ST_WAIT_FRAME) &&
                   (r_imm || frame_start || !spi_running);

  // Filter change is judged against the active bank, not the output pin,
  // so a settle in progress does not look like an HPF 0->1 transition.
  assign w_filter_change = (w_shadow.hpf_coef != r_act.hpf_coef) ||
                           (w_shadow.ctrl[CTRL_HPF_EN] && !r_act.ctrl[CTRL_HPF_EN]);
  assign w_need_settle   = w_filter_change && w_shadow.ctrl[CTRL_HPF_EN];

  // Settle ends on the frame that takes the counter to zero, or at once
  // when no more frames are coming.
  assign w_settle_end = !spi_running || (frame_start && (r_settle_cnt <= 8'd1));

  always_ff @(posedge dataclk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_act        <= CFG_RESET;
      r_hpf_en_out <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_imm        <= 1'b0;
      r_settle_cnt <= 8'd0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (commit_req) begin
            if (!w_valid) begin
              r_err <= 1'b1;
            end else begin
              r_state <= ST_WAIT_FRAME;
              r_busy  <= 1'b1;
              r_imm   <= !spi_running;
            end
          end
        end
        ST_WAIT_FRAME: begin
          if (w_apply) begin
            r_act <= w_shadow;
            r_imm <= 1'b0;
            if (w_need_settle) begin
              r_hpf_en_out <= 1'b0;
              r_settle_cnt <= SETTLE_CNT_INIT;
              r_state      <= ST_SETTLE;
            end else begin
              r_hpf_en_out <= w_shadow.ctrl[CTRL_HPF_EN];
              r_state      <= ST_IDLE;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (w_settle_end) begin
            r_settle_cnt <= 8'd0;
            r_hpf_en_out <= r_act.ctrl[CTRL_HPF_EN];
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end else if (frame_start) begin
            r_settle_cnt <= r_settle_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign commit_busy     = r_busy;
  assign commit_done     = r_done;
  assign commit_err      = r_err;
  assign DAC_thrsh_1     = r_act.thrsh_1;
  assign DAC_thrsh_2     = r_act.thrsh_2;
  assign DAC_start_win_1 = r_act.start_win_1;
  assign DAC_stop_win_1  = r_act.stop_win_1;
  assign DAC_start_win_2 = r_act.start_win_2;
  assign DAC_stop_win_2  = r_act.stop_win_2;
  assign DAC_stop_max    = r_act.stop_max;
  assign HPF_coefficient = r_act.hpf_coef;
  assign HPF_en          = r_hpf_en_out;
  assign DAC_fsm_mode    = r_act.ctrl[CTRL_FSM_MODE];
  assign DAC_thrsh_pol_1 = r_act.ctrl[CTRL_POL_1];
  assign DAC_thrsh_pol_2 = r_act.ctrl[CTRL_POL_2];
  assign DAC_edge_type   = r_act.ctrl[CTRL_EDGE_LSB +: 2];
  assign DAC_en          = r_act.ctrl[CTRL_DAC_EN_LSB +: 2];

endmodule
`default_nettype wire

// File: tb/tb_dac_cfg_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_dac_cfg_scheduler                                         |
// | Purpose : Directed self-checking bench for dac_cfg_scheduler.          |
// | Ports   : none                                                         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_dac_cfg_scheduler;

  logic        dataclk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic        spi_running = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_addr = 4'd0;
  logic [15:0] cfg_data = 16'd0;
  logic        commit_req = 1'b0;
  logic        commit_busy, commit_done, commit_err, addr_err;
  logic [15:0] DAC_thrsh_1, DAC_thrsh_2, DAC_start_win_1, DAC_stop_win_1;
  logic [15:0] DAC_start_win_2, DAC_stop_win_2, DAC_stop_max, HPF_coefficient;
  logic        HPF_en, DAC_fsm_mode, DAC_thrsh_pol_1, DAC_thrsh_pol_2;
  logic [1:0]  DAC_edge_type, DAC_en;

  int n_cmp = 0;
  int n_err = 0;

  dac_cfg_scheduler #(.SETTLE_FRAMES(4)) dut (
    .dataclk         (dataclk),
    .reset           (reset),
    .frame_start     (frame_start),
    .spi_running     (spi_running),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_addr        (cfg_addr),
    .cfg_data        (cfg_data),
    .commit_req      (commit_req),
    .commit_busy     (commit_busy),
    .commit_done     (commit_done),
    .commit_err      (commit_err),
    .addr_err        (addr_err),
    .DAC_thrsh_1     (DAC_thrsh_1),
    .DAC_thrsh_2     (DAC_thrsh_2),
    .DAC_start_win_1 (DAC_start_win_1),
    .DAC_stop_win_1  (DAC_stop_win_1),
    .DAC_start_win_2 (DAC_start_win_2),
    .DAC_stop_win_2  (DAC_stop_win_2),
    .DAC_stop_max    (DAC_stop_max),
    .HPF_coefficient (HPF_coefficient),
    .HPF_en          (HPF_en),
    .DAC_fsm_mode    (DAC_fsm_mode),
    .DAC_thrsh_pol_1 (DAC_thrsh_pol_1),
    .DAC_thrsh_pol_2 (DAC_thrsh_pol_2),
    .DAC_edge_type   (DAC_edge_type),
    .DAC_en          (DAC_en)
  );

  always #5 dataclk = ~dataclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // All stimulus changes on the falling edge; checks follow on a falling edge.
  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge dataclk);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    @(negedge dataclk);
    cfg_valid = 1'b0;
  endtask

  // Returns on the falling edge just after the edge that sampled commit_req.
  task automatic commit(input logic with_frame);
    @(negedge dataclk);
    commit_req  = 1'b1;
    frame_start = with_frame;
    #1;
    check("ready_low_on_req", cfg_ready, 0);
    @(negedge dataclk);
    commit_req  = 1'b0;
    frame_start = 1'b0;
  endtask

  // Returns on the falling edge just after the edge that sampled frame_start.
  task automatic frame();
    @(negedge dataclk);
    frame_start = 1'b1;
    @(negedge dataclk);
    frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic held;

    // ---------------- reset state ----------------
    repeat (3) @(negedge dataclk);
    reset = 1'b1;
    @(negedge dataclk);
    check("rst_thrsh_1", DAC_thrsh_1, 32768);
    check("rst_thrsh_2", DAC_thrsh_2, 32768);
    check("rst_hpf_en", HPF_en, 0);
    check("rst_busy", commit_busy, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_addr_err", addr_err, 0);

    // ---------------- write + commit while running ----------------
    spi_running = 1'b1;
    wr(4'd0, 16'd32255);
    wr(4'd1, 16'd30973);
    commit(1'b1);  // coincident frame_start must not apply
    check("t1_busy", commit_busy, 1);
    check("t1_ready_wait", cfg_ready, 0);
    check("t1_no_early_apply", DAC_thrsh_1, 32768);
    held = 1'b1;
    repeat (48) begin
      @(negedge dataclk);
      if (DAC_thrsh_1 !== 16'd32768 || DAC_thrsh_2 !== 16'd32768 || commit_done !== 1'b0)
        held = 1'b0;
    end
    check("t1_hold_before_frame", held, 1);
    frame();
    check("t1_thrsh_1", DAC_thrsh_1, 32255);
    check("t1_thrsh_2", DAC_thrsh_2, 30973);
    check("t1_done", commit_done, 1);
    check("t1_busy_clear", commit_busy, 0);
    @(negedge dataclk);
    check("t1_done_one_cycle", commit_done, 0);

    // ---------------- invalid bank ----------------
    wr(4'd2, 16'd4);
    wr(4'd3, 16'd2);
    wr(4'd6, 16'd8);
    commit(1'b0);
    check("t2_err", commit_err, 1);
    check("t2_busy", commit_busy, 0);
    check("t2_start_win_1", DAC_start_win_1, 0);
    check("t2_stop_max", DAC_stop_max, 0);
    @(negedge dataclk);
    check("t2_err_one_cycle", commit_err, 0);
    wr(4'd3, 16'd6);
    commit(1'b0);
    check("t2_no_err", commit_err, 0);
    frame();
    check("t2b_start_win_1", DAC_start_win_1, 4);
    check("t2b_stop_win_1", DAC_stop_win_1, 6);
    check("t2b_stop_max", DAC_stop_max, 8);
    check("t2b_done", commit_done, 1);

    // ---------------- HPF settle ----------------
    wr(4'd7, 16'd5894);
    wr(4'd8, 16'hABE5);  // edge=1, hpf_en=1, pol_2=1, dac_en=3; high byte ignored
    commit(1'b0);
    frame();  // frame 0: apply, enter settle
    check("t3_coef", HPF_coefficient, 5894);
    check("t3_hpf_en_held", HPF_en, 0);
    check("t3_dac_en", DAC_en, 3);
    check("t3_edge", DAC_edge_type, 1);
    check("t3_pol_1", DAC_thrsh_pol_1, 0);
    check("t3_pol_2", DAC_thrsh_pol_2, 1);
    check("t3_fsm_mode", DAC_fsm_mode, 0);
    check("t3_busy", commit_busy, 1);
    check("t3_no_done", commit_done, 0);
    for (int i = 1; i <= 3; i++) begin
      repeat (3) @(negedge dataclk);
      frame();
      check("t3_hpf_en_still_low", HPF_en, 0);
      check("t3_done_still_low", commit_done, 0);
    end
    repeat (3) @(negedge dataclk);
    frame();
    check("t3_hpf_en_rise", HPF_en, 1);
    check("t3_done", commit_done, 1);
    check("t3_busy_clear", commit_busy, 0);

    // ---------------- immediate apply, addr_err ----------------
    spi_running = 1'b0;
    wr(4'd0, 16'd1000);
    commit(1'b0);
    check("t4_busy", commit_busy, 1);
    check("t4_not_yet", DAC_thrsh_1, 32255);
    @(negedge dataclk);
    check("t4_thrsh_1", DAC_thrsh_1, 1000);
    check("t4_done", commit_done, 1);
    check("t4_busy_clear", commit_busy, 0);
    check("t4_hpf_en_kept", HPF_en, 1);
    wr(4'd12, 16'h1234);
    check("t4_addr_err", addr_err, 1);

    // ---------------- reset mid-commit ----------------
    spi_running = 1'b1;
    wr(4'd7, 16'd100);
    commit(1'b0);
    frame();
    check("t5_coef", HPF_coefficient, 100);
    check("t5_in_settle", HPF_en, 0);
    check("t5_busy", commit_busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_async_thrsh_1", DAC_thrsh_1, 32768);
    check("t5_async_coef", HPF_coefficient, 0);
    check("t5_async_dac_en", DAC_en, 0);
    check("t5_async_busy", commit_busy, 0);
    check("t5_async_addr_err", addr_err, 0);
    @(negedge dataclk);
    reset = 1'b1;
    @(negedge dataclk);
    check("t5_ready_idle", cfg_ready, 1);
    check("t5_busy_idle", commit_busy, 0);
    spi_running = 1'b0;
    wr(4'd0, 16'd777);
    commit(1'b0);
    @(negedge dataclk);
    check("t5_thrsh_1", DAC_thrsh_1, 777);
    check("t5_thrsh_2_reset", DAC_thrsh_2, 32768);
    check("t5_done", commit_done, 1);
    check("t5_hpf_en", HPF_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
